// File: rtl/sprite_slot_scheduler.sv
// Shares one sprite ROM between NUM_SLOTS screen slots: per-pixel hit test, ROM address, aligned slot id.
// Optional SPRITE_HFLIP_EN adds a per-slot horizontal mirror bit (cfg_flip).
package sprite_slot_scheduler_pkg;
    typedef struct packed {
        logic       en;
`ifdef SPRITE_HFLIP_EN
        logic       flip;
`endif
        logic [9:0] x;
        logic [9:0] y;
    } slot_t;
endpackage

module sprite_slot_hit
    import sprite_slot_scheduler_pkg::*;
#(
    parameter int SPR_W  = 35,
    parameter int SPR_H  = 58,
    parameter int ADDR_W = 11
) (
    input  slot_t              slot,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    output logic               hit,
    output logic [ADDR_W-1:0]  addr
);
    logic [10:0]       x_end, y_end;
    logic [9:0]        dx, dy;
    logic [ADDR_W-1:0] col;

    // 11-bit window ends so a sprite near column/row 1023 does not wrap to 0
    assign x_end = {1'b0, slot.x} + 11'(SPR_W);
    assign y_end = {1'b0, slot.y} + 11'(SPR_H);
    assign dx    = DrawX - slot.x;
    assign dy    = DrawY - slot.y;

    assign hit = slot.en && blank &&
                 (DrawX >= slot.x) && ({1'b0, DrawX} < x_end) &&
                 (DrawY >= slot.y) && ({1'b0, DrawY} < y_end);

`ifdef SPRITE_HFLIP_EN
    assign col = slot.flip ? ADDR_W'(SPR_W - 1) - ADDR_W'(dx) : ADDR_W'(dx);
`else
    assign col = ADDR_W'(dx);
`endif
    assign addr = col + ADDR_W'(dy) * ADDR_W'(SPR_W);
endmodule

module sprite_slot_scheduler
    import sprite_slot_scheduler_pkg::*;
#(
    parameter  int NUM_SLOTS = 4,
    parameter  int SPR_W     = 35,
    parameter  int SPR_H     = 58,
    parameter  int ADDR_W    = 11,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              cfg_we,
    input  logic [SLOT_W-1:0] cfg_slot,
    input  logic [9:0]        cfg_x,
    input  logic [9:0]        cfg_y,
    input  logic              cfg_en,
`ifdef SPRITE_HFLIP_EN
    input  logic              cfg_flip,
`endif
    output logic              cfg_ack,
    output logic              frame_start,
    output logic [ADDR_W-1:0] rom_address,
    output logic              hit_valid,
    output logic [SLOT_W-1:0] pix_slot
);
    slot_t [NUM_SLOTS-1:0]              shadow, active;
    slot_t                              new_slot;
    logic                               pending, accept, commit;
    logic [NUM_SLOTS-1:0]               hit;
    logic [NUM_SLOTS-1:0][ADDR_W-1:0]   addr;
    logic                               found;
    logic [SLOT_W-1:0]                  win, s1_slot;
    logic [ADDR_W-1:0]                  win_addr;
    logic [1:0]                         vld_pipe;

    assign accept = cfg_we && (32'(cfg_slot) < NUM_SLOTS);
    assign commit = pending && (DrawX == 10'd0) && (DrawY == 10'd0);

    always_comb begin
        new_slot    = '0;
        new_slot.en = cfg_en;
        new_slot.x  = cfg_x;
        new_slot.y  = cfg_y;
`ifdef SPRITE_HFLIP_EN
        new_slot.flip = cfg_flip;
`endif
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        sprite_slot_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W)) u_hit (
            .slot(active[i]), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
            .hit(hit[i]), .addr(addr[i])
        );
    end

    // Descending scan so the lowest-index hitting slot is the last assignment
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_addr = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                found    = 1'b1;
                win      = SLOT_W'(i);
                win_addr = addr[i];
            end
        end
    end

    // A write landing on the commit cycle goes to shadow and re-arms pending
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
            cfg_ack     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            cfg_ack     <= accept;
            frame_start <= commit;
            if (commit) active <= shadow;
            for (int i = 0; i < NUM_SLOTS; i++)
                if (accept && cfg_slot == SLOT_W'(i)) shadow[i] <= new_slot;
            if (accept)      pending <= 1'b1;
            else if (commit) pending <= 1'b0;
        end
    end

    // Stage 1 feeds the ROM (read on negedge); stage 2 lines id/valid up with q
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            rom_address <= '0;
            s1_slot     <= '0;
            pix_slot    <= '0;
            vld_pipe    <= '0;
        end else begin
            rom_address <= win_addr;
            s1_slot     <= win;
            pix_slot    <= s1_slot;
            vld_pipe    <= {vld_pipe[0], found};
        end
    end

    assign hit_valid = vld_pipe[1];
endmodule

// File: tb/tb_sprite_slot_scheduler.sv
// Directed bench for sprite_slot_scheduler; built with NUM_SLOTS=5 so slot 5 is an expressible out-of-range index.
module tb_sprite_slot_scheduler;
    localparam int NS = 5;
    localparam int SW = $clog2(NS);

    logic          vga_clk = 1'b0;
    logic          Reset;
    logic [9:0]    DrawX, DrawY;
    logic          blank;
    logic          cfg_we;
    logic [SW-1:0] cfg_slot;
    logic [9:0]    cfg_x, cfg_y;
    logic          cfg_en;
`ifdef SPRITE_HFLIP_EN
    logic          cfg_flip;
`endif
    logic          cfg_ack, frame_start, hit_valid;
    logic [10:0]   rom_address;
    logic [SW-1:0] pix_slot;

    int nvec = 0;
    int nerr = 0;

    sprite_slot_scheduler #(.NUM_SLOTS(NS), .SPR_W(35), .SPR_H(58), .ADDR_W(11)) dut (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en),
`ifdef SPRITE_HFLIP_EN
        .cfg_flip(cfg_flip),
`endif
        .cfg_ack(cfg_ack), .frame_start(frame_start), .rom_address(rom_address),
        .hit_valid(hit_valid), .pix_slot(pix_slot)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic px(input int x, input int y, input logic b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
    endtask

    task automatic cfg(input int s, input int x, input int y, input logic en);
        cfg_we   = 1'b1;
        cfg_slot = SW'(s);
        cfg_x    = 10'(x);
        cfg_y    = 10'(y);
        cfg_en   = en;
    endtask

    // Single write on an idle pixel, then check the ack pulse
    task automatic wr(input int s, input int x, input int y, input logic en, input logic ack_exp);
        px(500, 500, 1'b0);
        cfg(s, x, y, en);
        tick();
        cfg_we = 1'b0;
        chk("cfg_ack", 32'(cfg_ack), 32'(ack_exp));
    endtask

    // Pixel at (0,0) in blanking; frame_start is visible right after the edge
    task automatic frame(input logic fs_exp);
        px(0, 0, 1'b0);
        tick();
        chk("frame_start", 32'(frame_start), 32'(fs_exp));
        px(500, 500, 1'b0);
        tick();
        chk("frame_start_drop", 32'(frame_start), 0);
    endtask

    // One pixel: address after 1 cycle, valid/slot after 2
    task automatic probe(input string tag, input int x, input int y, input int addr_exp,
                         input logic hv_exp, input int slot_exp);
        px(x, y, 1'b1);
        tick();
        chk({tag, "_addr"}, 32'(rom_address), 32'(addr_exp));
        px(500, 500, 1'b0);
        tick();
        chk({tag, "_hv"}, 32'(hit_valid), 32'(hv_exp));
        chk({tag, "_slot"}, 32'(pix_slot), 32'(slot_exp));
    endtask

    initial begin
        Reset = 1'b1;
        cfg_we = 1'b0; cfg_slot = '0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0;
`ifdef SPRITE_HFLIP_EN
        cfg_flip = 1'b0;
`endif
        px(500, 500, 1'b0);
        tick();
        chk("rst_ack", 32'(cfg_ack), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_addr", 32'(rom_address), 0);
        chk("rst_hv", 32'(hit_valid), 0);
        chk("rst_slot", 32'(pix_slot), 0);
        Reset = 1'b0;
        tick();

        // slot 0 at (100,125): invisible until the next (0,0)
        wr(0, 100, 125, 1'b1, 1'b1);
        tick();
        chk("ack_one_cycle", 32'(cfg_ack), 0);
        probe("precommit", 101, 125, 0, 1'b0, 0);
        frame(1'b1);
        probe("s0_origin", 100, 125, 0, 1'b1, 0);
        probe("s0_69", 134, 126, 69, 1'b1, 0);
        probe("s0_x135", 135, 126, 0, 1'b0, 0);
        probe("s0_last", 134, 182, 2029, 1'b1, 0);
        probe("s0_y183", 134, 183, 0, 1'b0, 0);
        probe("s0_x99", 99, 125, 0, 1'b0, 0);
        px(101, 125, 1'b0);
        tick();
        chk("blanked_addr", 32'(rom_address), 0);

        // back-to-back overlap pair: lowest index wins
        px(500, 500, 1'b0);
        cfg(1, 200, 200, 1'b1);
        tick();
        chk("b2b_ack1", 32'(cfg_ack), 1);
        cfg(2, 190, 190, 1'b1);
        tick();
        cfg_we = 1'b0;
        chk("b2b_ack2", 32'(cfg_ack), 1);
        frame(1'b1);
        probe("ovl_s1", 205, 205, 180, 1'b1, 1);
        wr(1, 200, 200, 1'b0, 1'b1);
        probe("ovl_pending", 205, 205, 180, 1'b1, 1);
        frame(1'b1);
        probe("ovl_s2", 205, 205, 540, 1'b1, 2);

        // write landing exactly on the commit cycle
        wr(3, 300, 300, 1'b1, 1'b1);
        px(0, 0, 1'b0);
        cfg(3, 400, 400, 1'b1);
        tick();
        cfg_we = 1'b0;
        chk("cc_fs", 32'(frame_start), 1);
        chk("cc_ack", 32'(cfg_ack), 1);
        probe("cc_old", 301, 300, 1, 1'b1, 3);
        probe("cc_new_hidden", 401, 400, 0, 1'b0, 0);
        frame(1'b1);
        probe("cc_new", 401, 400, 1, 1'b1, 3);
        probe("cc_old_gone", 301, 300, 0, 1'b0, 0);

        // out-of-range slot: no ack, pending untouched
        wr(5, 0, 0, 1'b1, 1'b0);
        frame(1'b0);
        probe("oor_none", 10, 10, 0, 1'b0, 0);

        // window at the right edge must not wrap onto column 0
        wr(4, 1000, 0, 1'b1, 1'b1);
        frame(1'b1);
        for (int x = 0; x <= 10; x++) probe("wrap", x, 5, 0, 1'b0, 0);
        probe("edge_1000", 1000, 5, 175, 1'b1, 4);
        probe("edge_1023", 1023, 5, 198, 1'b1, 4);

        // asynchronous reset mid-stream clears outputs before the next edge
        px(134, 126, 1'b1);
        tick();
        chk("pre_rst_addr", 32'(rom_address), 69);
        px(134, 127, 1'b1);
        tick();
        chk("pre_rst_hv", 32'(hit_valid), 1);
        #2 Reset = 1'b1;
        #1;
        chk("async_addr", 32'(rom_address), 0);
        chk("async_hv", 32'(hit_valid), 0);
        tick();
        Reset = 1'b0;
        probe("post_rst", 134, 126, 0, 1'b0, 0);
        frame(1'b0);
        probe("post_rst_frame", 134, 126, 0, 1'b0, 0);

`ifdef SPRITE_HFLIP_EN
        cfg_flip = 1'b1;
        wr(0, 100, 125, 1'b1, 1'b1);
        cfg_flip = 1'b0;
        frame(1'b1);
        probe("flip_origin", 100, 125, 34, 1'b1, 0);
        probe("flip_right", 134, 126, 35, 1'b1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
